// File: rtl/mux_sel_arbiter_if.sv
// Bus between the round-robin mux-select arbiter (master side) and its requesters/mux (slave side).
// The lock signal exists only when MUX_SEL_ARBITER_LOCK_EN is defined.
interface mux_sel_arbiter_if #(
  parameter int NUM_REQ = 16,
  parameter int SEL_W   = 4
);
  logic               enable;
  logic [NUM_REQ-1:0] req;
  logic               data_in;
  logic [SEL_W-1:0]   sel;
  logic [NUM_REQ-1:0] grant;
  logic               busy;
  logic               sample_q;
  logic               sample_vld;
  logic               timeout;
`ifdef MUX_SEL_ARBITER_LOCK_EN
  logic               lock;
`endif

  modport master (
`ifdef MUX_SEL_ARBITER_LOCK_EN
    input  lock,
`endif
    input  enable, req, data_in,
    output sel, grant, busy, sample_q, sample_vld, timeout
  );

  modport slave (
`ifdef MUX_SEL_ARBITER_LOCK_EN
    output lock,
`endif
    output enable, req, data_in,
    input  sel, grant, busy, sample_q, sample_vld, timeout
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter sharing a 16:1 select mux; samples the mux output while a grant is held.
// Optional MUX_SEL_ARBITER_LOCK_EN adds a lock input that suppresses the hold-time limit.
module mux_sel_arbiter #(
  parameter int NUM_REQ  = 16,
  parameter int SEL_W    = 4,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_sel_arbiter_if.master    bus
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_e;

  state_e             state_q,      state_d;
  logic [SEL_W-1:0]   sel_q,        sel_d;
  logic [NUM_REQ-1:0] grant_q,      grant_d;
  logic               busy_q,       busy_d;
  logic               sample_q,     sample_d;
  logic               sample_vld_q, sample_vld_d;
  logic               timeout_q,    timeout_d;
  logic [CNT_W-1:0]   hold_cnt_q,   hold_cnt_d;
  logic [SEL_W-1:0]   last_idx_q,   last_idx_d;

  logic [SEL_W-1:0]   winner;
  logic               hold_max;
  logic               cur_req;
  logic               lock_on;

  // Scan starts just past the last served index; last_idx itself is checked last.
  function automatic logic [SEL_W-1:0] pick_winner(input logic [NUM_REQ-1:0] r,
                                                    input logic [SEL_W-1:0]   last);
    logic found;
    int   idx;
    pick_winner = last;
    found       = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && r[idx]) begin
        pick_winner = SEL_W'(idx);
        found       = 1'b1;
      end
    end
  endfunction

`ifdef MUX_SEL_ARBITER_LOCK_EN
  assign lock_on = bus.lock;
`else
  assign lock_on = 1'b0;
`endif

  assign winner   = pick_winner(bus.req, last_idx_q);
  assign hold_max = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
  assign cur_req  = bus.req[sel_q];

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    grant_d      = grant_q;
    busy_d       = busy_q;
    sample_d     = sample_q;
    sample_vld_d = 1'b0;
    timeout_d    = 1'b0;
    hold_cnt_d   = hold_cnt_q;
    last_idx_d   = last_idx_q;

    case (state_q)
      S_GRANT: begin
        sample_d     = bus.data_in;
        sample_vld_d = 1'b1;
        hold_cnt_d   = hold_max ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
        if (!cur_req || (hold_max && !lock_on)) begin
          state_d    = S_GAP;
          grant_d    = '0;
          busy_d     = 1'b0;
          last_idx_d = sel_q;
          // Still requesting at release means the hold limit ended the grant.
          timeout_d  = cur_req;
        end
      end
      default: begin
        // IDLE and GAP arbitrate identically; sel keeps its last value.
        grant_d = '0;
        busy_d  = 1'b0;
        if (bus.enable && (|bus.req)) begin
          state_d         = S_GRANT;
          grant_d[winner] = 1'b1;
          sel_d           = winner;
          busy_d          = 1'b1;
          hold_cnt_d      = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      sample_q     <= 1'b0;
      sample_vld_q <= 1'b0;
      timeout_q    <= 1'b0;
      hold_cnt_q   <= '0;
      last_idx_q   <= SEL_W'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      sample_q     <= sample_d;
      sample_vld_q <= sample_vld_d;
      timeout_q    <= timeout_d;
      hold_cnt_q   <= hold_cnt_d;
      last_idx_q   <= last_idx_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.grant      = grant_q;
  assign bus.busy       = busy_q;
  assign bus.sample_q   = sample_q;
  assign bus.sample_vld = sample_vld_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: a vector table for single-cycle behaviour plus
// directed sequences for rotation, wrap, self re-grant, enable drop, reset mid-grant and lock.
module tb_mux_sel_arbiter;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mux_sel_arbiter_if #(.NUM_REQ(16), .SEL_W(4)) bus ();

  mux_sel_arbiter #(.NUM_REQ(16), .SEL_W(4), .MAX_HOLD(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [15:0] req;
    logic        din;
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        busy;
    logic        smp;
    logic        vld;
    logic        to;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.enable  = 1'b0;
    bus.req     = '0;
    bus.data_in = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.enable  = 1'b0;
    bus.req     = '0;
    bus.data_in = 1'b0;
`ifdef MUX_SEL_ARBITER_LOCK_EN
    bus.lock    = 1'b0;
`endif

    //          rst  en   req       din   grant     sel   busy  smp   vld   to
    vecs[0] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 16'h0008, 1'b1, 16'h0008, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 16'h0008, 1'b1, 16'h0008, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 16'h0010, 1'b0, 16'h0000, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 16'h0010, 1'b1, 16'h0010, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 16'h0010, 1'b1, 16'h0010, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 8; i++) begin
      rst_n       = vecs[i].rst_n;
      bus.enable  = vecs[i].en;
      bus.req     = vecs[i].req;
      bus.data_in = vecs[i].din;
      tick();
      check($sformatf("vec%0d grant", i), 32'(bus.grant),      32'(vecs[i].grant));
      check($sformatf("vec%0d sel", i),   32'(bus.sel),        32'(vecs[i].sel));
      check($sformatf("vec%0d busy", i),  32'(bus.busy),       32'(vecs[i].busy));
      check($sformatf("vec%0d smp", i),   32'(bus.sample_q),   32'(vecs[i].smp));
      check($sformatf("vec%0d vld", i),   32'(bus.sample_vld), 32'(vecs[i].vld));
      check($sformatf("vec%0d to", i),    32'(bus.timeout),    32'(vecs[i].to));
    end

    // Full rotation with every line requesting: 0..15 then 0 again, 8 on + 1 gap each.
    do_reset();
    bus.enable = 1'b1;
    bus.req    = 16'hFFFF;
    tick();
    for (int g = 0; g < 17; g++) begin
      for (int c = 0; c < 8; c++) begin
        check($sformatf("rot g%0d c%0d grant", g, c), 32'(bus.grant), 32'(1) << (g % 16));
        check($sformatf("rot g%0d c%0d to", g, c),    32'(bus.timeout), 32'd0);
        tick();
      end
      check($sformatf("rot g%0d gap grant", g), 32'(bus.grant),   32'd0);
      check($sformatf("rot g%0d gap sel", g),   32'(bus.sel),     32'(g % 16));
      check($sformatf("rot g%0d gap to", g),    32'(bus.timeout), 32'd1);
      tick();
    end

    // Wrap: last_idx=15 picks 0, then last_idx=0 picks 15.
    do_reset();
    bus.enable = 1'b1;
    bus.req    = 16'h8001;
    tick();
    for (int c = 0; c < 8; c++) begin
      check($sformatf("wrap0 c%0d grant", c), 32'(bus.grant), 32'h0001);
      tick();
    end
    check("wrap gap grant", 32'(bus.grant),   32'd0);
    check("wrap gap to",    32'(bus.timeout), 32'd1);
    tick();
    check("wrap15 grant", 32'(bus.grant), 32'h8000);
    check("wrap15 sel",   32'(bus.sel),   32'd15);

    // Lone requester 5 is re-granted after each gap.
    do_reset();
    bus.enable = 1'b1;
    bus.req    = 16'h0020;
    for (int t = 1; t <= 20; t++) begin
      tick();
      check($sformatf("self t%0d grant", t), 32'(bus.grant),
            (((t - 1) % 9) < 8) ? 32'h0020 : 32'd0);
      check($sformatf("self t%0d to", t), 32'(bus.timeout),
            (((t - 1) % 9) == 8) ? 32'd1 : 32'd0);
      check($sformatf("self t%0d sel", t), 32'(bus.sel), 32'd5);
    end

    // Enable drop mid-grant: grant to 2 completes, then IDLE until enable returns.
    do_reset();
    bus.enable = 1'b1;
    bus.req    = 16'h0004;
    tick();
    check("en grant2", 32'(bus.grant), 32'h0004);
    bus.enable = 1'b0;
    bus.req    = 16'h0006;
    tick();
    check("en hold1", 32'(bus.grant), 32'h0004);
    tick();
    check("en hold2", 32'(bus.grant), 32'h0004);
    bus.req = 16'h0002;
    tick();
    check("en gap grant", 32'(bus.grant),   32'd0);
    check("en gap to",    32'(bus.timeout), 32'd0);
    tick();
    check("en idle1 grant", 32'(bus.grant), 32'd0);
    tick();
    check("en idle2 grant", 32'(bus.grant), 32'd0);
    check("en idle2 busy",  32'(bus.busy),  32'd0);
    bus.enable = 1'b1;
    tick();
    check("en regrant1 grant", 32'(bus.grant), 32'h0002);
    check("en regrant1 sel",   32'(bus.sel),   32'd1);

    // Reset mid-grant of 7 restores every reset value, including priority of 0.
    do_reset();
    bus.enable  = 1'b1;
    bus.req     = 16'h0080;
    bus.data_in = 1'b1;
    tick();
    check("rst grant7", 32'(bus.grant), 32'h0080);
    tick();
    check("rst smp before", 32'(bus.sample_q), 32'd1);
    rst_n = 1'b0;
    tick();
    check("rst grant", 32'(bus.grant),      32'd0);
    check("rst sel",   32'(bus.sel),        32'd0);
    check("rst busy",  32'(bus.busy),       32'd0);
    check("rst smp",   32'(bus.sample_q),   32'd0);
    check("rst vld",   32'(bus.sample_vld), 32'd0);
    check("rst to",    32'(bus.timeout),    32'd0);
    rst_n   = 1'b1;
    bus.req = 16'h0081;
    tick();
    check("rst first grant", 32'(bus.grant), 32'h0001);
    check("rst first sel",   32'(bus.sel),   32'd0);

`ifdef MUX_SEL_ARBITER_LOCK_EN
    // Lock holds the grant past the limit with no timeout; release only on req drop.
    do_reset();
    bus.enable = 1'b1;
    bus.lock   = 1'b1;
    bus.req    = 16'h0020;
    for (int t = 1; t <= 12; t++) begin
      tick();
      check($sformatf("lock t%0d grant", t), 32'(bus.grant),   32'h0020);
      check($sformatf("lock t%0d to", t),    32'(bus.timeout), 32'd0);
    end
    bus.req = 16'h0000;
    tick();
    check("lock rel grant", 32'(bus.grant),   32'd0);
    check("lock rel to",    32'(bus.timeout), 32'd0);
    bus.lock = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
